line_nbr_pack: RTL
==================

# line_nbr_pack

- Post-processing stage directly upstream of the three-direction neighbour register.
- Accepts one disparity per cycle in raster order and keeps a one-row line buffer.
- Emits, per accepted pixel, the packed previous-row neighbours at 45° (upper-right), 90° (above) and 135° (upper-left) on the `{135, 90, 45}` bus that the downstream register splits.
- Image borders are filled with a constant marker.

## Interface
- `DWIDTH`, 7: field base width. Each field is `DWIDTH+2` bits.
- `IMG_W`, 640: pixels per row, ≥ 2.
- `IMG_H`, 480: rows per frame, ≥ 2.
- `FILL`, all ones (`DWIDTH+2` bits): value substituted for missing neighbours.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `clken`  in  1: global clock enable. Low means the whole block holds.
- `din_valid`  in  1: `din` carries a pixel.
- `din`  in  `DWIDTH+2`: current-row disparity.
- `sof`  in  1: start of frame, qualifies the accepted pixel. Present only with `LINE_NBR_SOF_EN`.
- `dout`  out  `3*DWIDTH+6`: packed neighbours.
  - `[DWIDTH+1:0]` = 45° (upper-right, col+1).
  - `[2*DWIDTH+3:DWIDTH+2]` = 90° (above).
  - `[3*DWIDTH+5:2*DWIDTH+4]` = 135° (upper-left, col−1).
- `dout_valid`  out  1: `dout` holds a new beat.
- `dout_eol`  out  1: the beat is for column `IMG_W-1`.

## Operation
**Accept.** A pixel is accepted when `clken && din_valid`. There is no backpressure.

**Counters.** Column counter `col` runs 0..`IMG_W-1`. Row counter `row` runs 0..`IMG_H-1`.
- On accept at `col==IMG_W-1`: `col` wraps to 0 and `row` increments.
- At `row==IMG_H-1`, `row` wraps to 0, which starts a new frame.

**Line buffer.**
- Register array of `IMG_W` entries, `DWIDTH+2` bits each, with asynchronous read.
- Array contents are not reset. Row 0 masking makes them irrelevant.

**Neighbour hold.** Register `hold` keeps the previous-row value at col−1.

**On accept of pixel (row, col):**
- Output 90° = `mem[col]`.
- Output 45° = `mem[col+1]`, or `FILL` if `col==IMG_W-1`.
- Output 135° = `hold`, or `FILL` if `col==0`.
- If `row==0`, all three fields are `FILL`.
- Then `mem[col]` ← `din` and `hold` ← old `mem[col]`. The read happens before the write in the same cycle.

**Handshake with the downstream register.**
- `dout_valid` is 1 for exactly one `clken` cycle after each accept.
- In a `clken` cycle with no accept, `dout_valid` is 0 and `dout` holds its value.
- When `clken==0`, `dout`, `dout_valid`, `dout_eol`, the counters, `hold` and the array are all frozen.
- `dout_eol` equals (`col==IMG_W-1`) of the pixel being output. It is valid only with `dout_valid`.

**Reset.** `rst` has priority over `clken`. Its effect takes place on the next rising edge:
- `dout`=0, `dout_valid`=0, `dout_eol`=0, `col`=0, `row`=0, `hold`=0.
- After a mid-frame reset, the next accepted pixel is treated as (0,0).

## Timing
- Latency is 1 `clken`-enabled cycle from accept to `dout_valid`.
- Throughput is 1 pixel per cycle. Back-to-back rows need no gap.
- A row wrap and a new-row pixel on consecutive cycles need no special case. Position (row, col) of an accepted pixel is fully determined by the counter values at accept.
- A pixel at `col==IMG_W-1` of row r reads `mem[IMG_W-1]` (row r−1). That entry is overwritten in the same cycle.

## Configuration
**`LINE_NBR_SOF_EN` defined:**
- The `sof` port exists.
- An accepted pixel with `sof==1` is treated as (0,0), whatever the counter state. Counters then continue from `col=1`, `row=0`.
- `sof` on a non-accepted cycle is ignored.

**Not defined:**
- No `sof` port.
- Frame alignment relies only on reset and the `IMG_H` wrap.

## Structure
- **Shared package `pp_pkg`:**
  - Function or localparam for field width `DWIDTH+2`.
  - The `FILL` default.
  - Packing offsets for 45°, 90° and 135°, shared with the downstream neighbour register.
- **Sub-module `line_nbr_ram`:**
  - `IMG_W`-deep, asynchronous read-before-write array.
  - Two read addresses (`col`, `col+1`) and one write port, all gated by `clken`.
- Counters, border masking and output registers live in `line_nbr_pack`.

## Test plan
All scenarios use `DWIDTH`=7, `IMG_W`=4, `IMG_H`=3 and `FILL`=0x1FF.
1. **Row 0.** Stream 1,2,3,4 → four beats, each `dout`={0x1FF,0x1FF,0x1FF}; `dout_eol` only on the 4th.
2. **Row 1.** Then stream 5,6,7,8. Each beat is `dout`={135°, 90°, 45°}:
   - (1,0) → {0x1FF, 1, 2}
   - (1,1) → {1, 2, 3}
   - (1,2) → {2, 3, 4}
   - (1,3) → {3, 4, 0x1FF}
3. **Row and frame wrap.** Continue with row 2 and then a 13th pixel. The row 2 beats use the row 1 values 5..8. The 13th pixel is row 0 of the next frame and outputs all `FILL`.
4. **Stalls.**
   - Drop `clken` for 3 cycles mid-row → all outputs frozen, no extra `dout_valid`.
   - `din_valid`=0 with `clken`=1 → `dout_valid`=0, `dout` unchanged.
5. **Mid-row reset.** Assert `rst` for 1 cycle at (1,2) → next edge gives all outputs 0. The next pixel outputs all `FILL` and is counted as (0,0).
6. **`sof` resync (`LINE_NBR_SOF_EN` only).** `sof` with the pixel at (1,1) → that beat is all `FILL`, and the following pixel is counted as (0,1).

Source files
------------

// File: rtl/pp_pkg.sv
// Shared post-processing definitions: field width, default border marker and
// the packing offsets of the {135, 90, 45} neighbour bus. The downstream
// neighbour register imports the same offsets so both sides agree on layout.
package pp_pkg;

  // Neighbour directions, numbered by their field slot on the packed bus
  typedef enum logic [1:0] {
    DIR_45  = 2'd0,
    DIR_90  = 2'd1,
    DIR_135 = 2'd2
  } dir_e;

  localparam int DWIDTH_DEF  = 7;
  localparam int NUM_DIRS    = 3;

  // A disparity field carries two extra bits beyond the base width
  function automatic int field_w(input int dwidth);
    return dwidth + 2;
  endfunction

  localparam int FIELD_W_DEF = DWIDTH_DEF + 2;

  // Default marker for missing neighbours (all ones)
  localparam logic [FIELD_W_DEF-1:0] FILL_DEF = '1;

  // Lowest bit of a direction's field within the packed bus
  function automatic int nbr_lsb(input dir_e dir, input int dwidth);
    return int'(dir) * field_w(dwidth);
  endfunction

endpackage

// File: rtl/line_nbr_ram.sv
// One-row line buffer: register array with two asynchronous read ports and
// one write port. Reads see the old contents during a same-cycle write, which
// gives read-before-write behaviour. Contents are intentionally never reset.
module line_nbr_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clken,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_a,
  output logic [WIDTH-1:0] rdata_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

  // Store the current-row pixel; held whenever the block is not enabled
  always_ff @(posedge clk) begin
    if (clken && we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/line_nbr_pack.sv
// Line-buffer neighbour packer. For each accepted pixel it emits the previous
// row's upper-left (135), above (90) and upper-right (45) values, packed as
// {135, 90, 45}, one clken-enabled cycle later. Missing neighbours at the
// image borders (row 0, first and last column) are replaced by FILL.
// Optional feature: define LINE_NBR_SOF_EN to add a start-of-frame input that
// forces the accepted pixel to position (0,0).
module line_nbr_pack
  import pp_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter logic [DWIDTH+1:0] FILL = {(DWIDTH+2){1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clken,
  input  logic                  din_valid,
  input  logic [DWIDTH+1:0]     din,
`ifdef LINE_NBR_SOF_EN
  input  logic                  sof,
`endif
  output logic [3*DWIDTH+5:0]   dout,
  output logic                  dout_valid,
  output logic                  dout_eol
);

  localparam int FW  = field_w(DWIDTH);
  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int L45  = nbr_lsb(DIR_45,  DWIDTH);
  localparam int L90  = nbr_lsb(DIR_90,  DWIDTH);
  localparam int L135 = nbr_lsb(DIR_135, DWIDTH);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [FW-1:0] hold;

  logic          accept;
  logic          pix_sof;
  logic [CW-1:0] pix_col;
  logic [RW-1:0] pix_row;
  logic          pix_last_col;
  logic [CW-1:0] raddr_right;
  logic [FW-1:0] above;
  logic [FW-1:0] above_right;
  logic [3*DWIDTH+5:0] packed_nbrs;

`ifdef LINE_NBR_SOF_EN
  assign pix_sof = sof;
`else
  assign pix_sof = 1'b0;
`endif

  assign accept       = clken && din_valid && !rst;
  assign pix_col      = pix_sof ? '0 : col;
  assign pix_row      = pix_sof ? '0 : row;
  assign pix_last_col = (pix_col == COL_LAST);
  // Past the last column the upper-right read is masked, so any in-range address will do
  assign raddr_right  = pix_last_col ? '0 : pix_col + CW'(1);

  line_nbr_ram #(
    .WIDTH (FW),
    .DEPTH (IMG_W),
    .AW    (CW)
  ) u_ram (
    .clk     (clk),
    .clken   (clken),
    .we      (accept),
    .waddr   (pix_col),
    .wdata   (din),
    .raddr_a (pix_col),
    .raddr_b (raddr_right),
    .rdata_a (above),
    .rdata_b (above_right)
  );

  // Apply border masking and pack the three neighbours onto the output bus
  always_comb begin
    packed_nbrs = '0;
    packed_nbrs[L90 +: FW]  = (pix_row == '0) ? FILL : above;
    packed_nbrs[L45 +: FW]  = ((pix_row == '0) || pix_last_col) ? FILL : above_right;
    packed_nbrs[L135 +: FW] = ((pix_row == '0) || (pix_col == '0)) ? FILL : hold;
  end

  // Advance the raster position and remember the above value for the next column
  always_ff @(posedge clk) begin
    if (rst) begin
      col  <= '0;
      row  <= '0;
      hold <= '0;
    end else if (accept) begin
      hold <= above;
      if (pix_last_col) begin
        col <= '0;
        row <= (pix_row == ROW_LAST) ? '0 : pix_row + RW'(1);
      end else begin
        col <= pix_col + CW'(1);
        row <= pix_row;
      end
    end
  end

  // Register one output beat per accepted pixel; hold everything when disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_eol   <= 1'b0;
    end else if (clken) begin
      if (din_valid) begin
        dout       <= packed_nbrs;
        dout_valid <= 1'b1;
        dout_eol   <= pix_last_col;
      end else begin
        dout_valid <= 1'b0;
        dout_eol   <= 1'b0;
      end
    end
  end

endmodule
